// File: rtl/cube_scan_sequencer.sv
// LED cube scan sequencer: steps through colour/plane/frame slots, asks the loader to
// shift each slot's data under a blanked output, then shows the slot for a fixed dwell.
module cube_scan_sequencer #(
    parameter int PLANES       = 7,
    parameter int COLORS       = 3,
    parameter int ADDR_STRIDE  = 21,
    parameter int BLANK_CYCLES = 16,
    parameter int DWELL_CYCLES = 2000,
    parameter int FRAME_REPEAT = 50,
    parameter int LOAD_TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  frame_last,
    input  logic        load_done,
    output logic        load_start,
    output logic [15:0] rom_addr,
    output logic [1:0]  color_sel,
    output logic [2:0]  plane_sel,
    output logic [7:0]  frame_idx,
    output logic        oe_n,
    output logic        frame_tick,
    output logic        load_err
);
    localparam int TMAX0 = (BLANK_CYCLES > DWELL_CYCLES) ? BLANK_CYCLES : DWELL_CYCLES;
    localparam int TMAX  = (TMAX0 > LOAD_TIMEOUT) ? TMAX0 : LOAD_TIMEOUT;
    localparam int TW    = $clog2(TMAX + 1);
    localparam int SW    = (FRAME_REPEAT > 1) ? $clog2(FRAME_REPEAT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        BLANK,
        LOAD_REQ,
        LOAD_WAIT,
        DISPLAY
    } state_t;

    state_t         state, state_next;
    logic [TW-1:0]  timer, timer_next;
    logic [SW-1:0]  scan, scan_next;
    logic [1:0]     color_next;
    logic [2:0]     plane_next;
    logic [7:0]     frame_next;
    logic [15:0]    addr_next;
    logic           advance;
    logic           err_set;
    logic           tick_next;

    // Moore outputs: load_start only in LOAD_REQ, oe_n low only in DISPLAY, so they can never overlap.
    assign load_start = (state == LOAD_REQ);
    assign oe_n       = (state != DISPLAY);

    always_comb begin
        state_next = state;
        timer_next = timer + TW'(1);
        advance    = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                timer_next = '0;
                if (enable) state_next = BLANK;
            end
            BLANK: begin
                if (timer == TW'(BLANK_CYCLES - 1)) begin
                    state_next = LOAD_REQ;
                    timer_next = '0;
                end
            end
            LOAD_REQ: begin
                state_next = LOAD_WAIT;
                timer_next = '0;
            end
            LOAD_WAIT: begin
                // A done arriving in the timeout cycle wins over the timeout.
                if (load_done) begin
                    state_next = DISPLAY;
                    timer_next = '0;
                end else if (timer == TW'(LOAD_TIMEOUT - 1)) begin
                    state_next = DISPLAY;
                    timer_next = '0;
                    err_set    = 1'b1;
                end
            end
            DISPLAY: begin
                if (timer == TW'(DWELL_CYCLES - 1)) begin
                    advance    = 1'b1;
                    timer_next = '0;
                    state_next = enable ? BLANK : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                timer_next = '0;
            end
        endcase
    end

    always_comb begin
        color_next = color_sel;
        plane_next = plane_sel;
        scan_next  = scan;
        frame_next = frame_idx;
        tick_next  = 1'b0;
        if (advance) begin
            if (color_sel == 2'(COLORS - 1)) begin
                color_next = '0;
                if (plane_sel == 3'(PLANES - 1)) begin
                    plane_next = '0;
                    if (scan == SW'(FRAME_REPEAT - 1)) begin
                        scan_next  = '0;
                        tick_next  = 1'b1;
                        frame_next = (frame_idx >= frame_last) ? '0 : frame_idx + 8'd1;
                    end else begin
                        scan_next = scan + SW'(1);
                    end
                end else begin
                    plane_next = plane_sel + 3'd1;
                end
            end else begin
                color_next = color_sel + 2'd1;
            end
        end
        addr_next = 16'(int'(frame_next) * ADDR_STRIDE + int'(plane_next) * COLORS + int'(color_next));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            scan       <= '0;
            color_sel  <= '0;
            plane_sel  <= '0;
            frame_idx  <= '0;
            rom_addr   <= '0;
            frame_tick <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            state      <= state_next;
            timer      <= timer_next;
            frame_tick <= tick_next;
            if (err_set) load_err <= 1'b1;
            if (advance) begin
                color_sel <= color_next;
                plane_sel <= plane_next;
                scan      <= scan_next;
                frame_idx <= frame_next;
                rom_addr  <= addr_next;
            end
        end
    end
endmodule

// File: tb/tb_cube_scan_sequencer.sv
// Self-checking bench for cube_scan_sequencer: a slot-count reference model predicts
// addresses, frame wraps, dwell/blank/load timing and the sticky load error.
module tb_cube_scan_sequencer;
    localparam int PLANES  = 7;
    localparam int COLORS  = 3;
    localparam int STRIDE  = 21;
    localparam int BLANK   = 2;
    localparam int DWELL   = 4;
    localparam int REPEAT  = 2;
    localparam int TIMEOUT = 16;
    localparam int SLOTS_PER_SCAN  = PLANES * COLORS;
    localparam int SLOTS_PER_FRAME = SLOTS_PER_SCAN * REPEAT;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [7:0]  frame_last;
    logic        load_done;
    logic        load_start;
    logic [15:0] rom_addr;
    logic [1:0]  color_sel;
    logic [2:0]  plane_sel;
    logic [7:0]  frame_idx;
    logic        oe_n;
    logic        frame_tick;
    logic        load_err;

    int checks = 0;
    int errors = 0;

    bit loader_on = 1'b0;
    bit stray_on  = 1'b0;
    int lat_fixed = 0;
    int last_lat  = 0;
    int countdown = 0;
    bit prev_ls   = 1'b0;

    // Reference model: slot number within the current frame, frame index, sticky error.
    int m_n     = 0;
    int m_frame = 0;
    bit m_err   = 1'b0;

    cube_scan_sequencer #(
        .PLANES       (PLANES),
        .COLORS       (COLORS),
        .ADDR_STRIDE  (STRIDE),
        .BLANK_CYCLES (BLANK),
        .DWELL_CYCLES (DWELL),
        .FRAME_REPEAT (REPEAT),
        .LOAD_TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .frame_last (frame_last),
        .load_done  (load_done),
        .load_start (load_start),
        .rom_addr   (rom_addr),
        .color_sel  (color_sel),
        .plane_sel  (plane_sel),
        .frame_idx  (frame_idx),
        .oe_n       (oe_n),
        .frame_tick (frame_tick),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    function automatic int m_addr();
        return m_frame * STRIDE + (m_n % SLOTS_PER_SCAN);
    endfunction

    task automatic model_advance(output bit tick);
        tick = 1'b0;
        m_n++;
        if (m_n == SLOTS_PER_FRAME) begin
            m_n     = 0;
            tick    = 1'b1;
            m_frame = (m_frame >= int'(frame_last)) ? 0 : m_frame + 1;
        end
    endtask

    // Loader stand-in: answers load_start after a latency, optionally injects stray done pulses.
    initial begin : loader
        load_done = 1'b0;
        forever begin
            @(negedge clk);
            load_done = 1'b0;
            if (reset === 1'b1) begin
                countdown = 0;
            end else if (countdown > 0) begin
                countdown--;
                if (countdown == 0) load_done = 1'b1;
            end else if (loader_on && load_start === 1'b1) begin
                last_lat  = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 5));
                countdown = last_lat;
            end else if (loader_on && stray_on && oe_n === 1'b1 && $urandom_range(0, 2) == 0) begin
                load_done = 1'b1;
            end
        end
    end

    initial begin : ls_monitor
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                prev_ls = 1'b0;
            end else begin
                if (load_start === 1'b1) begin
                    checks++;
                    if (oe_n !== 1'b1 || prev_ls) begin
                        errors++;
                        $display("FAIL load_start_exclusive: oe_n=%b prev_load_start=%b, required oe_n=1 prev=0", oe_n, prev_ls);
                    end
                end
                prev_ls = (load_start === 1'b1);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // One full slot: load request, load wait, dwell, then the slot advance.
    task automatic run_slot(input int gap_exp, input bit drop);
        int n;
        int dwell;
        int wait_exp;
        bit tick;
        logic [15:0] slot_addr;
        n = 0;
        while (load_start !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (load_start !== 1'b1) begin
            errors++;
            $display("FAIL load_start_timeout: none after %0d cycles, required within 60", n);
            return;
        end
        if (gap_exp >= 0) begin
            checks++;
            if (n != gap_exp) begin
                errors++;
                $display("FAIL load_start_gap: got %0d cycles, required %0d", n, gap_exp);
            end
        end
        slot_addr = 16'(m_addr());
        checks++;
        if (rom_addr !== slot_addr || color_sel !== 2'(m_n % COLORS) ||
            plane_sel !== 3'((m_n / COLORS) % PLANES) || frame_idx !== 8'(m_frame)) begin
            errors++;
            $display("FAIL slot_select: addr=%0d c=%0d p=%0d f=%0d, required addr=%0d c=%0d p=%0d f=%0d",
                     rom_addr, color_sel, plane_sel, frame_idx, slot_addr, m_n % COLORS,
                     (m_n / COLORS) % PLANES, m_frame);
        end
        n = 0;
        while (oe_n === 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
            if (n == 1 && drop) enable = 1'b0;
        end
        if (!loader_on) wait_exp = TIMEOUT + 1;
        else wait_exp = ((last_lat > TIMEOUT) ? TIMEOUT : last_lat) + 1;
        if (!loader_on || last_lat > TIMEOUT) m_err = 1'b1;
        checks++;
        if (n != wait_exp) begin
            errors++;
            $display("FAIL load_wait_len: got %0d cycles, required %0d", n, wait_exp);
            return;
        end
        checks++;
        if (load_err !== m_err) begin
            errors++;
            $display("FAIL load_err: got %b, required %b", load_err, m_err);
        end
        dwell = 0;
        while (oe_n === 1'b0 && dwell < 60) begin
            checks++;
            if (rom_addr !== slot_addr || load_start !== 1'b0 || frame_tick !== 1'b0) begin
                errors++;
                $display("FAIL display_hold: addr=%0d ls=%b tick=%b, required addr=%0d ls=0 tick=0",
                         rom_addr, load_start, frame_tick, slot_addr);
            end
            @(negedge clk);
            dwell++;
        end
        checks++;
        if (dwell != DWELL) begin
            errors++;
            $display("FAIL dwell_len: got %0d cycles, required %0d", dwell, DWELL);
        end
        model_advance(tick);
        checks++;
        if (frame_tick !== tick || rom_addr !== 16'(m_addr()) || frame_idx !== 8'(m_frame)) begin
            errors++;
            $display("FAIL slot_advance: tick=%b addr=%0d f=%0d, required tick=%b addr=%0d f=%0d",
                     frame_tick, rom_addr, frame_idx, tick, m_addr(), m_frame);
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        enable     = 1'b0;
        frame_last = 8'd2;
        repeat (3) @(negedge clk);
        checks++;
        if (oe_n !== 1'b1 || load_start !== 1'b0 || frame_tick !== 1'b0 || load_err !== 1'b0 ||
            rom_addr !== 16'd0 || color_sel !== 2'd0 || plane_sel !== 3'd0 || frame_idx !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: oe_n=%b ls=%b tick=%b err=%b addr=%0d c=%0d p=%0d f=%0d, required 1 0 0 0 0 0 0 0",
                     oe_n, load_start, frame_tick, load_err, rom_addr, color_sel, plane_sel, frame_idx);
        end
        reset   = 1'b0;
        m_n     = 0;
        m_frame = 0;
        m_err   = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (oe_n !== 1'b1 || load_start !== 1'b0 || rom_addr !== 16'd0) begin
            errors++;
            $display("FAIL idle_hold: oe_n=%b ls=%b addr=%0d, required 1 0 0", oe_n, load_start, rom_addr);
        end
    endtask

    task automatic test_first_scan();
        loader_on = 1'b1;
        stray_on  = 1'b0;
        lat_fixed = 3;
        enable    = 1'b1;
        run_slot(3, 1'b0);
        for (int i = 1; i < SLOTS_PER_SCAN; i++) run_slot(2, 1'b0);
    endtask

    task automatic test_frames();
        lat_fixed  = 0;
        stray_on   = 1'b1;
        frame_last = 8'd2;
        for (int i = 0; i < 3 * SLOTS_PER_FRAME - SLOTS_PER_SCAN; i++) run_slot(2, 1'b0);
        checks++;
        if (frame_idx !== 8'd0 || rom_addr !== 16'd0) begin
            errors++;
            $display("FAIL frame_wrap: f=%0d addr=%0d, required f=0 addr=0", frame_idx, rom_addr);
        end
    endtask

    task automatic test_frame_last();
        for (int i = 0; i < 6 * SLOTS_PER_FRAME; i++) begin
            if (i % 15 == 7) frame_last = 8'($urandom_range(0, 4));
            run_slot(2, 1'b0);
        end
    endtask

    task automatic test_done_at_timeout();
        stray_on  = 1'b0;
        lat_fixed = TIMEOUT;
        run_slot(2, 1'b0);
    endtask

    task automatic test_timeout();
        lat_fixed = TIMEOUT + 1;
        run_slot(2, 1'b0);
        loader_on = 1'b0;
        run_slot(2, 1'b0);
        run_slot(2, 1'b0);
        loader_on = 1'b1;
        lat_fixed = 0;
        run_slot(2, 1'b0);
        run_slot(2, 1'b0);
    endtask

    task automatic test_enable_drop();
        lat_fixed = 3;
        run_slot(2, 1'b1);
        repeat (6) begin
            checks++;
            if (oe_n !== 1'b1 || load_start !== 1'b0 || rom_addr !== 16'(m_addr()) ||
                color_sel !== 2'(m_n % COLORS) || frame_idx !== 8'(m_frame)) begin
                errors++;
                $display("FAIL idle_after_drop: oe_n=%b ls=%b addr=%0d, required oe_n=1 ls=0 addr=%0d",
                         oe_n, load_start, rom_addr, m_addr());
            end
            @(negedge clk);
        end
        enable = 1'b1;
        run_slot(3, 1'b0);
        run_slot(2, 1'b0);
    endtask

    task automatic test_reset_mid();
        int n;
        frame_last = 8'd1;
        lat_fixed  = 0;
        stray_on   = 1'b1;
        for (int i = 0; i < 300 && m_addr() != 30; i++) run_slot(2, 1'b0);
        n = 0;
        while (load_start !== 1'b1 && n < 60) begin @(negedge clk); n++; end
        n = 0;
        while (oe_n !== 1'b0 && n < 60) begin @(negedge clk); n++; end
        @(negedge clk);
        checks++;
        if (oe_n !== 1'b0 || rom_addr !== 16'd30 || load_err !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_display: oe_n=%b addr=%0d err=%b, required oe_n=0 addr=30 err=1",
                     oe_n, rom_addr, load_err);
        end
        reset  = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if (oe_n !== 1'b1 || rom_addr !== 16'd0 || load_err !== 1'b0 || load_start !== 1'b0 ||
            color_sel !== 2'd0 || plane_sel !== 3'd0 || frame_idx !== 8'd0 || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: oe_n=%b addr=%0d err=%b ls=%b c=%0d p=%0d f=%0d, required 1 0 0 0 0 0 0",
                     oe_n, rom_addr, load_err, load_start, color_sel, plane_sel, frame_idx);
        end
        reset   = 1'b0;
        m_n     = 0;
        m_frame = 0;
        m_err   = 1'b0;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        run_slot(3, 1'b0);
        run_slot(2, 1'b0);
    endtask

    initial begin
        test_reset();
        test_first_scan();
        test_frames();
        test_frame_last();
        test_done_at_timeout();
        test_timeout();
        test_enable_drop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cube_scan_sequencer.md
CUBE_SCAN_SEQUENCER -- requirements
Module: cube_scan_sequencer

Interface
REQ-001 SHALL have parameter PLANES, default 7, number of cube planes scanned.
REQ-002 SHALL have parameter COLORS, default 3, colour slots per plane (0=R, 1=G, 2=B).
REQ-003 SHALL have parameter ADDR_STRIDE, default 21, ROM words per frame (PLANES*COLORS).
REQ-004 SHALL have parameter BLANK_CYCLES, default 16, oe_n-high guard before each load.
REQ-005 SHALL have parameter DWELL_CYCLES, default 2000, oe_n-low display time per slot.
REQ-006 SHALL have parameter FRAME_REPEAT, default 50, full cube scans per frame.
REQ-007 SHALL have parameter LOAD_TIMEOUT, default 1023, max cycles waiting for load_done.
REQ-008 clk  in  1  system clock.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 enable  in  1  run scan when high.
REQ-011 frame_last  in  8  index of last valid frame.
REQ-012 load_done  in  1  loader finished shifting and latching the current slot.
REQ-013 load_start  out  1  one-cycle pulse requesting the loader to shift the slot data.
REQ-014 rom_addr  out  16  frame ROM address of the current slot.
REQ-015 color_sel  out  2  current colour slot.
REQ-016 plane_sel  out  3  current plane.
REQ-017 frame_idx  out  8  current frame.
REQ-018 oe_n  out  1  active-low output enable to the shift registers.
REQ-019 frame_tick  out  1  one-cycle pulse on frame advance.
REQ-020 load_err  out  1  sticky load-timeout flag.

Function
REQ-021 SHALL implement states IDLE, BLANK, LOAD_REQ, LOAD_WAIT, DISPLAY.
REQ-022 IDLE: oe_n=1; enable=1 -> BLANK next cycle.
REQ-023 BLANK: oe_n=1 for exactly BLANK_CYCLES cycles, then -> LOAD_REQ.
REQ-024 LOAD_REQ: load_start=1 for exactly one cycle, oe_n=1, -> LOAD_WAIT.
REQ-025 LOAD_WAIT: oe_n=1; load_done=1 -> DISPLAY; after LOAD_TIMEOUT cycles without load_done, set load_err and -> DISPLAY.
REQ-026 load_done and timeout in the same cycle: treated as done, load_err unchanged.
REQ-027 load_done outside LOAD_WAIT SHALL be ignored.
REQ-028 DISPLAY: oe_n=0 for exactly DWELL_CYCLES cycles; at the last cycle, advance slot (REQ-029) and -> BLANK if enable=1, else -> IDLE.
REQ-029 Slot advance: color_sel 0..COLORS-1 wraps to 0 and increments plane_sel; plane_sel PLANES-1 wraps to 0 and increments the scan counter; scan counter FRAME_REPEAT-1 wraps to 0 and advances the frame.
REQ-030 Frame advance: if frame_idx >= frame_last, frame_idx <- 0, else frame_idx+1; frame_tick=1 in the same cycle frame_idx updates.
REQ-031 frame_last SHALL be sampled only at frame advance; changes mid-frame take effect at the next advance.
REQ-032 rom_addr SHALL be registered as frame_idx*ADDR_STRIDE + plane_sel*COLORS + color_sel, updated together with the slot counters, and stable from BLANK entry through DISPLAY exit.
REQ-033 Deasserting enable SHALL affect only the DISPLAY exit and IDLE; an in-progress BLANK/LOAD/DISPLAY sequence completes; counters hold in IDLE.
REQ-034 load_start and oe_n=0 SHALL never be active in the same cycle.

Reset
REQ-035 On reset: state IDLE, oe_n=1, load_start=0, frame_tick=0, load_err=0, color_sel=0, plane_sel=0, frame_idx=0, scan counter=0, rom_addr=0, all timers cleared.
REQ-036 Reset mid-operation SHALL take effect the next cycle from any state; load_err is cleared only by reset.

Verification (PLANES=7, COLORS=3, ADDR_STRIDE=21, BLANK_CYCLES=2, DWELL_CYCLES=4, FRAME_REPEAT=2, LOAD_TIMEOUT=16)
REQ-037 Reset, enable=1, load_done returned 3 cycles after each load_start -> first load_start 3 cycles after enable (1 IDLE->BLANK + 2 BLANK), oe_n low 4 cycles per slot, rom_addr steps 0,1,2,...,20.
REQ-038 frame_last=2, run 3 frames -> frame_idx 0,1,2,0; rom_addr base 0,21,42,0; frame_tick once per 42 slots.
REQ-039 load_done never asserted -> load_err=1 after 16 LOAD_WAIT cycles, DISPLAY entered, scan continues.
REQ-040 enable dropped during LOAD_WAIT -> DISPLAY completes, IDLE with oe_n=1 and counters held; re-enable resumes at next slot address.
REQ-041 reset asserted during DISPLAY at slot rom_addr=30 -> next cycle oe_n=1, rom_addr=0, load_err=0, state IDLE.
REQ-042 Assertion throughout all tests: load_start never coincides with oe_n=0; load_start never two consecutive cycles.
